// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file: FSM encoding and default sizes.
package regfile_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  localparam int unsigned DataWDefault  = 32;
  localparam int unsigned AddrWDefault  = 5;
  localparam int unsigned NRdDefault    = 2;
  localparam int unsigned NWrDefault    = 2;
  localparam bit          BypassDefault = 1'b1;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port priority select for one target address; the highest-indexed matching port wins.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned N_WR   = NWrDefault
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  // Ascending scan: a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < int'(N_WR); w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported flop-based register file with r0 hardwired to zero, pending scoreboard,
// optional write-to-read bypass and a one-register-per-cycle background clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned N_RD   = NRdDefault,
  parameter int unsigned N_WR   = NWrDefault,
  parameter bit          BYPASS = BypassDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_pend,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [ADDR_W-1:0]      alloc_addr,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic              wr_hit [1:DEPTH-1];
  logic [DATA_W-1:0] wr_val [1:DEPTH-1];

  for (genvar i = 1; i < DEPTH; i++) begin : g_store_arb
    regfile_wr_arb #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N_WR   (N_WR)
    ) u_arb (
      .addr    (ADDR_W'(i)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (wr_hit[i]),
      .data    (wr_val[i])
    );
  end

  // Set beats clear: alloc is applied after the write-side clears.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < int'(N_WR); w++) begin
      if (wr_en[w]) pend_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_en) pend_d[alloc_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      pend_q  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          for (int i = 1; i < int'(DEPTH); i++) begin
            if (wr_hit[i]) mem_q[i] <= wr_val[i];
          end
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= ADDR_W'(1);
            pend_q  <= '0;
          end else begin
            pend_q <= pend_d;
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clr_busy = (state_q == StClear);

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra         = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_pend[k] = pend_q[ra];

    if (BYPASS) begin : g_byp
      logic              byp_hit;
      logic [DATA_W-1:0] byp_val;
      regfile_wr_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_WR   (N_WR)
      ) u_byp_arb (
        .addr    (ra),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hit     (byp_hit),
        .data    (byp_val)
      );
      assign rd_data[k*DATA_W +: DATA_W] =
          (byp_hit && (ra != '0) && (state_q == StIdle)) ? byp_val : mem_q[ra];
    end else begin : g_nobyp
      assign rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass instances share the same stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        clr_req;
  logic        clr_busy, clr_busy_nb;

  int n_chk = 0;
  int n_bad = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(2), .BYPASS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pend    (rd_pend),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(2), .BYPASS(1'b0)) dut_nb (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data_nb),
    .rd_pend    (rd_pend_nb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    clr_req  = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*5 +: 5] = 5'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*5 +: 5] = 5'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = 5'(a);
  endtask

  logic [31:0] acc;
  logic        pacc;
  int          n_busy;

  initial begin
    idle_in();
    rd_addr = '0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    set_rd(0, 5); set_rd(1, 7); #1;
    check("rst_rd0", {32'h0, rd_data[31:0]}, 64'h0);
    check("rst_rd1", {32'h0, rd_data[63:32]}, 64'h0);
    check("rst_pend", {62'h0, rd_pend}, 64'h0);
    check("rst_busy", {63'h0, clr_busy}, 64'h0);

    // Bypass vs stored value
    wr(0, 5, 32'h1234_5678); tick(); idle_in();
    wr(0, 5, 32'hDEAD_BEEF); set_rd(1, 5); #1;
    check("byp_same", {32'h0, rd_data[63:32]}, 64'hDEAD_BEEF);
    check("nobyp_same", {32'h0, rd_data_nb[63:32]}, 64'h1234_5678);
    tick(); idle_in(); #1;
    check("byp_next", {32'h0, rd_data[63:32]}, 64'hDEAD_BEEF);
    check("nobyp_next", {32'h0, rd_data_nb[63:32]}, 64'hDEAD_BEEF);

    // Same-address write collision: port 1 wins
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_rd(0, 7); #1;
    check("coll_byp", {32'h0, rd_data[31:0]}, 64'h22);
    tick(); idle_in(); #1;
    check("coll_store", {32'h0, rd_data[31:0]}, 64'h22);
    check("coll_store_nb", {32'h0, rd_data_nb[31:0]}, 64'h22);

    // r0 hardwired
    wr(0, 0, 32'hFFFF_FFFF); alloc(0); set_rd(0, 0); set_rd(1, 0); #1;
    check("r0_byp", rd_data, 64'h0);
    tick(); idle_in(); #1;
    check("r0_data", rd_data, 64'h0);
    check("r0_pend", {62'h0, rd_pend}, 64'h0);

    // Pending scoreboard
    alloc(3); set_rd(0, 3); #1;
    check("pend_nobyp", {63'h0, rd_pend[0]}, 64'h0);
    tick(); idle_in(); #1;
    check("pend_alloc", {63'h0, rd_pend[0]}, 64'h1);
    wr(0, 3, 32'h33); alloc(3); tick(); idle_in(); #1;
    check("pend_setwins", {63'h0, rd_pend[0]}, 64'h1);
    wr(1, 3, 32'h34); #1;
    check("pend_hold", {63'h0, rd_pend[0]}, 64'h1);
    tick(); idle_in(); #1;
    check("pend_clr", {63'h0, rd_pend[0]}, 64'h0);

    // Fill r1..r31, then background clear
    for (int i = 1; i < 32; i += 2) begin
      wr(0, i, 32'h1000_0000 + 32'(i));
      if (i + 1 < 32) wr(1, i + 1, 32'h1000_0000 + 32'(i + 1));
      tick(); idle_in();
    end
    set_rd(0, 31); #1;
    check("fill_r31", {32'h0, rd_data[31:0]}, 64'h1000_001F);
    alloc(9); tick(); idle_in();
    set_rd(1, 9); #1;
    check("pend_r9", {63'h0, rd_pend[1]}, 64'h1);
    clr_req = 1'b1; wr(0, 2, 32'hAAAA_0002); tick(); idle_in();
    wr(0, 4, 32'h0000_0BAD); alloc(6); clr_req = 1'b1; set_rd(0, 4); set_rd(1, 9); #1;
    check("clr_nobyp", {32'h0, rd_data[31:0]}, 64'h1000_0004);
    check("clr_pend_zero", {63'h0, rd_pend[1]}, 64'h0);
    n_busy = 0;
    for (int c = 0; c < 100 && clr_busy; c++) begin
      n_busy++;
      tick();
    end
    idle_in();
    check("clr_cycles", 64'(n_busy), 64'd31);
    check("clr_done", {63'h0, clr_busy}, 64'h0);
    acc = '0; pacc = 1'b0;
    for (int a = 1; a < 32; a++) begin
      set_rd(0, a); #1;
      acc  = acc | rd_data[31:0];
      pacc = pacc | rd_pend[0];
    end
    check("clr_all_zero", {32'h0, acc}, 64'h0);
    check("clr_pend_all", {63'h0, pacc}, 64'h0);

    // Reset in the 10th cycle of CLEAR
    wr(0, 20, 32'h55); wr(1, 31, 32'h66); tick(); idle_in();
    clr_req = 1'b1; tick(); idle_in();
    for (int c = 0; c < 9; c++) tick();
    check("clr10_busy", {63'h0, clr_busy}, 64'h1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("abort_busy", {63'h0, clr_busy}, 64'h0);
    acc = '0; pacc = 1'b0;
    for (int a = 1; a < 32; a++) begin
      set_rd(1, a); #1;
      acc  = acc | rd_data[63:32];
      pacc = pacc | rd_pend[1];
    end
    check("abort_zero", {32'h0, acc}, 64'h0);
    check("abort_pend", {63'h0, pacc}, 64'h0);

    // Reset beats write, alloc and clr_req
    wr(0, 8, 32'h88); alloc(8); clr_req = 1'b1; reset = 1'b1; tick();
    reset = 1'b0; idle_in(); set_rd(0, 8); #1;
    check("rstpri_data", {32'h0, rd_data[31:0]}, 64'h0);
    check("rstpri_pend", {63'h0, rd_pend[0]}, 64'h0);
    check("rstpri_busy", {63'h0, clr_busy}, 64'h0);
    wr(1, 8, 32'h77); tick(); idle_in(); #1;
    check("post_rst_wr", {32'h0, rd_data[31:0]}, 64'h77);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter N_RD, default 2, number of read ports.
REQ-004 SHALL have parameter N_WR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous active-high reset
- rd_addr  input  N_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  output  N_RD*DATA_W  read data, packed the same way
- rd_pend  output  N_RD  pending (scoreboard) bit of each read address
- wr_en  input  N_WR  write enables
- wr_addr  input  N_WR*ADDR_W  write addresses
- wr_data  input  N_WR*DATA_W  write data
- alloc_en  input  1  mark a destination register pending
- alloc_addr  input  ADDR_W  register to mark pending
- clr_req  input  1  request a background clear of all registers
- clr_busy  output  1  clear sequence in progress

Function
REQ-008 SHALL hardwire register 0: reads return 0, writes and alloc to address 0 are ignored, and rd_pend for address 0 is 0.
REQ-009 SHALL perform reads combinationally, with zero cycles of latency.
REQ-010 SHALL, when BYPASS=1, return wr_data of an enabled write port whose wr_addr matches a nonzero rd_addr in the same cycle; when BYPASS=0, it SHALL return the stored value.
REQ-011 SHALL store enabled writes on the rising edge of clk.
REQ-012 SHALL resolve simultaneous writes to the same address by letting the highest-indexed port win, for both storage and bypass.
REQ-013 SHALL keep a DEPTH-bit pending vector: alloc_en sets bit alloc_addr; any enabled write clears bit wr_addr.
REQ-014 SHALL give set priority when alloc and write target the same address in the same cycle, so the bit ends at 1.
REQ-015 SHALL drive rd_pend[k] combinationally from the registered pending bit, with no bypass of the same-cycle alloc or write.
REQ-016 SHALL implement FSM states IDLE and CLEAR: IDLE goes to CLEAR on clr_req; CLEAR returns to IDLE after the cycle that clears register DEPTH-1.
REQ-017 SHALL, in CLEAR, zero one register per cycle in ascending order from 1 to DEPTH-1, using an ADDR_W-bit counter, so CLEAR lasts DEPTH-1 cycles.
REQ-018 SHALL clear the entire pending vector on the edge that enters CLEAR.
REQ-019 SHALL assert clr_busy exactly while in CLEAR (registered state decode).
REQ-020 SHALL ignore writes, alloc_en and clr_req while in CLEAR; reads SHALL return current array contents, and bypass SHALL be disabled in CLEAR.
REQ-021 SHALL, on clr_req together with writes in IDLE, perform the writes on that edge and then enter CLEAR, so those writes are later cleared.

Reset
REQ-022 SHALL, with reset=1 at a rising edge, zero all registers 1..DEPTH-1, zero the pending vector, put the FSM in IDLE and zero the clear counter.
REQ-023 SHALL give reset priority over writes, alloc and clr_req in the same cycle; reset during CLEAR SHALL abort it with clr_busy=0 next cycle.
REQ-024 SHALL hold outputs after reset at: rd_data=0, rd_pend=0, clr_busy=0.

Structure
REQ-025 SHALL place FSM state encoding (IDLE=0, CLEAR=1) and default parameter values in shared package regfile_pkg.
REQ-026 SHALL use one sub-module, regfile_wr_arb, which performs per-address write-port priority select (REQ-012) and is shared by the storage and bypass paths.
REQ-027 SHALL contain no other sub-modules; the array SHALL be flip-flop based.

Verification
REQ-028 SHALL cover: write r5=0xDEADBEEF on port 0 -> same-cycle rd_data port 1 (addr 5) = 0xDEADBEEF with BYPASS=1, or the old value with BYPASS=0; next cycle = 0xDEADBEEF.
REQ-029 SHALL cover: ports 0 and 1 both write r7 with 0x11 and 0x22 -> stored and bypassed value = 0x22.
REQ-030 SHALL cover: write r0=0xFFFFFFFF and alloc r0 -> rd_data(addr 0)=0 and rd_pend=0.
REQ-031 SHALL cover: alloc r3 -> rd_pend(addr 3)=1 next cycle; write r3 and alloc r3 in the same cycle -> stays 1; write r3 alone -> 0 next cycle.
REQ-032 SHALL cover: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high for exactly 31 cycles, writes during CLEAR dropped, then all reads return 0.
REQ-033 SHALL cover: reset asserted in the 10th cycle of CLEAR -> next cycle clr_busy=0, all registers 0, pending vector 0.
